bin_to_bcd_seq: RTL
===================

Name: bin_to_bcd_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter using shift-and-add-3 (double-dabble), one input bit per clock. It replaces per-digit compare chains with a uniform datapath and adds a start/done handshake, overflow saturation and leading-zero blanking. The score/HUD path uses it to drive the HEX display digit decoders, and any other numeric readout can use it too.

Parameters:
IN_WIDTH, 16, width of the unsigned binary input (2..32).
NUM_DIGITS, 4, number of BCD digits presented at the output (1..10).
SATURATE, 1, 1: out-of-range value clamps to all nines; 0: output is the value modulo 10^NUM_DIGITS.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a conversion of bin_in; accepted only when ready=1.
bin_in  input  IN_WIDTH  unsigned value; sampled on the accepting edge only.
ready  output  1  high in IDLE; converter can accept start.
done  output  1  one-cycle pulse; new bcd_out/overflow/digit_en valid from this cycle.
bcd_out  output  4*NUM_DIGITS  packed digits; digit 0 (ones) at [3:0], digit k at [4k+3:4k].
digit_en  output  NUM_DIGITS  leading-zero blank mask; bit k=1 if digit k is to be displayed.
overflow  output  1  last converted value exceeded 10^NUM_DIGITS-1.

Behaviour:
- Reset (async assert): state=IDLE, ready=1, done=0, bcd_out=0, digit_en=1 (ones only), overflow=0. Reset mid-conversion aborts it with no done pulse.
- FSM states:
  - IDLE: ready=1. start=1 latches bin_in into the shift register, clears the internal BCD register and sets bit counter=IN_WIDTH. Goes to SHIFT.
  - SHIFT: each cycle, add 3 to every internal digit >=5, then shift {bcd,bin} left 1. Counter decrements. After the IN_WIDTH-th shift, goes to FINISH.
  - FINISH: computes clamp/overflow and registers the outputs. done=1 for this one cycle. Goes to IDLE.
- Latency: the accepting edge is edge 0. done is high in the cycle after edge IN_WIDTH+1. ready is low from the cycle after edge 0 until done. Throughput is one conversion per IN_WIDTH+2 cycles.
- Internal BCD register width is DD_DIGITS = digits needed for 2^IN_WIDTH-1. This is independent of NUM_DIGITS, so the double-dabble is never truncated.
- overflow = (latched bin_in > MAX_VAL), where MAX_VAL = 10^NUM_DIGITS-1. If 2^IN_WIDTH-1 <= MAX_VAL, overflow is constant 0.
- SATURATE=1 with overflow: every output digit is 9 and digit_en is all ones.
- SATURATE=0 with overflow: output is the low NUM_DIGITS internal digits.
- digit_en[0]=1 always. For k>0, digit_en[k]=1 iff some digit j>=k is nonzero.
- Outputs hold their values between conversions; they are updated only in FINISH.
- start while ready=0 is ignored, not queued. start in the cycle the FSM re-enters IDLE (the cycle done=1 is shown) is accepted, giving back-to-back operation.
- bin_in changes after the accepting edge have no effect.

Decomposition:
- Package bcd_pkg:
  - state typedef (IDLE, SHIFT, FINISH).
  - function bcd_digits_for_width(w), used for DD_DIGITS.
  - function pow10_minus1(n), giving MAX_VAL at 64-bit width.
  - constant BCD_NINE = 4'd9.
- One sub-module: bcd_add3_digit (combinational, 4-bit in, 4-bit out, +3 if >=5), instantiated DD_DIGITS times by generate.

Test Plan:
- IN_WIDTH=16, NUM_DIGITS=4: start with bin_in=1234 -> done exactly 18 cycles after the accepting edge (edge 17 + 1). Digits 3..0 are 1,2,3,4; digit_en=1111; overflow=0.
- bin_in=0 -> bcd_out=0000, digit_en=0001. bin_in=7 -> digits 0,0,0,7, digit_en=0001. bin_in=40 -> digit_en=0011.
- SATURATE=1, bin_in=12345 -> digits 9,9,9,9, overflow=1. SATURATE=0, bin_in=12345 -> digits 2,3,4,5, overflow=1. bin_in=9999 -> 9,9,9,9, overflow=0.
- IN_WIDTH=16, NUM_DIGITS=5, bin_in=65535 -> digits 6,5,5,3,5; overflow=0; digit_en=11111.
- Pulse start=1 with bin_in=500 during SHIFT of a 1234 conversion -> ignored; result stays 1234. Raise start=1 with 500 in the cycle done=1 is shown -> accepted; next done shows 0,5,0,0 with digit_en=0111.
- Assert reset at cycle 8 of a conversion -> outputs go immediately to reset values, no done pulse. After release, ready=1 and a new conversion of 42 gives 0,0,4,2.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types, constants and elaboration-time helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SHIFT  = 2'd1;
   localparam state_t ST_FINISH = 2'd2;

   localparam logic [3:0] BCD_NINE = 4'd9;

   // Decimal digits needed to represent 2^w-1 (at least one).
   function automatic int unsigned bcd_digits_for_width(input int unsigned w);
      logic [63:0]  v;
      int unsigned  n;
      v = (64'd1 << w) - 64'd1;
      n = 0;
      for (int unsigned i = 0; i < 20; i++) begin
         if (v != 64'd0) begin
            v = v / 64'd10;
            n = n + 1;
         end
      end
      if (n == 0) n = 1;
      return n;
   endfunction

   function automatic logic [63:0] pow10_minus1(input int unsigned n);
      logic [63:0] p;
      p = 64'd1;
      for (int unsigned i = 0; i < 20; i++) begin
         if (i < n) p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3_digit (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with start/done handshake, overflow saturation and leading-zero blanking.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = 16,
   parameter int unsigned NUM_DIGITS = 4,
   parameter bit          SATURATE   = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [IN_WIDTH-1:0]     bin_in,
   output logic                    ready,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    overflow
);

   localparam int unsigned DD_DIGITS  = bcd_digits_for_width(IN_WIDTH);
   localparam int unsigned BCD_W      = 4 * DD_DIGITS;
   localparam int unsigned OUT_W      = 4 * NUM_DIGITS;
   localparam int unsigned EXT_DIGITS = (DD_DIGITS > NUM_DIGITS) ? DD_DIGITS : NUM_DIGITS;
   localparam int unsigned EXT_W      = 4 * EXT_DIGITS;
   localparam int unsigned CNT_W      = $clog2(IN_WIDTH + 1);

   localparam logic [63:0] MAX_VAL      = pow10_minus1(NUM_DIGITS);
   localparam logic [63:0] IN_MAX       = (64'd1 << IN_WIDTH) - 64'd1;
   localparam bit          OVF_POSSIBLE = (IN_MAX > MAX_VAL);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IN_WIDTH-1:0] r_bin;
   logic [BCD_W-1:0]    r_bcd;
   logic [BCD_W-1:0]    w_bcd_adj;
   logic [CNT_W-1:0]    r_cnt;
   logic [EXT_W-1:0]    w_bcd_ext;
   logic                w_ovf;
   logic [OUT_W-1:0]    w_digits;
   logic [NUM_DIGITS-1:0] w_en;

   for (genvar g = 0; g < DD_DIGITS; g++) begin : g_add3
      bcd_add3_digit u_add3 (
         .i_digit (r_bcd[4*g +: 4]),
         .o_digit (w_bcd_adj[4*g +: 4])
      );
   end

   // A nonzero digit above the displayed ones means the value exceeded MAX_VAL.
   assign w_bcd_ext = EXT_W'(r_bcd);
   assign w_ovf     = OVF_POSSIBLE && (|(w_bcd_ext >> OUT_W));
   assign w_digits  = (w_ovf && SATURATE) ? {NUM_DIGITS{BCD_NINE}} : w_bcd_ext[OUT_W-1:0];

   assign w_en[0] = 1'b1;
   for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_blank
      assign w_en[k] = |w_digits[OUT_W-1:4*k];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_state_nxt = ST_SHIFT;
         ST_SHIFT:  if (r_cnt == CNT_W'(1)) w_state_nxt = ST_FINISH;
         ST_FINISH: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs; results only change in FINISH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bin    <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         ready    <= 1'b1;
         done     <= 1'b0;
         bcd_out  <= '0;
         digit_en <= NUM_DIGITS'(1);
         overflow <= 1'b0;
      end else begin
         ready <= (w_state_nxt == ST_IDLE);
         done  <= (r_state == ST_FINISH);
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_bin <= bin_in;
                  r_bcd <= '0;
                  r_cnt <= CNT_W'(IN_WIDTH);
               end
            end
            ST_SHIFT: begin
               r_bcd <= BCD_W'({w_bcd_adj, r_bin[IN_WIDTH-1]});
               r_bin <= IN_WIDTH'({r_bin, 1'b0});
               r_cnt <= r_cnt - CNT_W'(1);
            end
            ST_FINISH: begin
               bcd_out  <= w_digits;
               digit_en <= w_en;
               overflow <= w_ovf;
            end
            default: ;
         endcase
      end
   end

endmodule
